// File: rtl/serial_pkg.sv
// Shared types for the serial packet transmitter: FSM states, byte-select codes and the
// default sync byte.
package serial_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StWaitLo,
    StWaitHi
  } state_e;

  typedef enum logic [1:0] {
    SEL_SYNC,
    SEL_LEN,
    SEL_PAY,
    SEL_CSUM
  } sel_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/serial_byte_fifo.sv
// Synchronous byte FIFO with a single-entry pop and a bulk drop used to discard the
// rest of an aborted payload.
module serial_byte_fifo #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [7:0]    i_data,
  input  logic          i_pop,
  input  logic [CW-1:0] i_drop,
  output logic [7:0]    o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_rd_step;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push    = i_push & ~o_full;
  assign w_pop     = i_pop & ~o_empty;
  assign w_rd_step = CW'(w_pop) + i_drop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so pointer arithmetic wraps on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= r_rd_ptr + AW'(w_rd_step);
      r_count  <= r_count + CW'(w_push) - w_rd_step;
    end
  end

endmodule

// File: rtl/serial_packet_tx.sv
// Framed packet transmitter: SYNC, LEN, payload, CSUM handed byte-by-byte to a byte sender.
// Optional watchdog abort enabled by defining SERIAL_PKT_TIMEOUT_EN.
module serial_packet_tx
  import serial_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT,
`ifdef SERIAL_PKT_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 4096,
`endif
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          start,
  input  logic [7:0]    start_len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [7:0]    tx_data,
  output logic          tx_e,
  input  logic          tx_avail,
  output logic [CW-1:0] fifo_count
);

  state_e        r_state;
  sel_e          r_sel;
  logic [7:0]    r_len;
  logic [7:0]    r_csum;
  logic [7:0]    r_pay_cnt;
  logic [7:0]    r_tx_data;
  logic          r_tx_e;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic [7:0]    w_head;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic [CW-1:0] w_drop;
  logic          w_len_bad;
  logic          w_abort;

  assign w_pop     = (r_state == StLoad) && (r_sel == SEL_PAY) && !w_empty;
  assign w_len_bad = (start_len == 8'd0) || ({1'b0, start_len} > 9'(w_count));

  serial_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (in_valid),
    .i_data (in_data),
    .i_pop  (w_pop),
    .i_drop (w_drop),
    .o_head (w_head),
    .o_count(w_count),
    .o_full (w_full),
    .o_empty(w_empty)
  );

`ifdef SERIAL_PKT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tmo;
  logic          w_wait_stay;

  assign w_wait_stay = ((r_state == StWaitLo) && tx_avail) ||
                       ((r_state == StWaitHi) && !tx_avail);
  assign w_abort     = w_wait_stay && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  // Bytes already loaded have left the FIFO; only the unloaded remainder is dropped.
  assign w_drop      = w_abort ? CW'(r_len - r_pay_cnt) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (w_wait_stay && !w_abort) begin
      r_tmo <= r_tmo + TW'(1);
    end else begin
      r_tmo <= '0;
    end
  end
`else
  assign w_abort = 1'b0;
  assign w_drop  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_sel     <= SEL_SYNC;
      r_len     <= '0;
      r_csum    <= '0;
      r_pay_cnt <= '0;
      r_tx_data <= '0;
      r_tx_e    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_tx_e <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            if (w_len_bad) begin
              r_err <= 1'b1;
            end else begin
              r_err     <= 1'b0;
              r_len     <= start_len;
              r_csum    <= start_len;
              r_pay_cnt <= '0;
              r_busy    <= 1'b1;
              r_sel     <= SEL_SYNC;
              r_state   <= StLoad;
            end
          end
        end
        StLoad: begin
          unique case (r_sel)
            SEL_SYNC: r_tx_data <= SYNC_BYTE;
            SEL_LEN:  r_tx_data <= r_len;
            SEL_PAY: begin
              r_tx_data <= w_head;
              r_csum    <= r_csum ^ w_head;
              r_pay_cnt <= r_pay_cnt + 8'd1;
            end
            SEL_CSUM: r_tx_data <= r_csum;
            default:  r_tx_data <= r_tx_data;
          endcase
          r_state <= StIssue;
        end
        StIssue: begin
          if (tx_avail) begin
            r_tx_e  <= 1'b1;
            r_state <= StWaitLo;
          end
        end
        StWaitLo: begin
          if (!tx_avail) begin
            r_state <= StWaitHi;
          end
        end
        StWaitHi: begin
          if (tx_avail) begin
            r_state <= StLoad;
            unique case (r_sel)
              SEL_SYNC: r_sel <= SEL_LEN;
              SEL_LEN:  r_sel <= SEL_PAY;
              SEL_PAY: begin
                if (r_pay_cnt == r_len) begin
                  r_sel <= SEL_CSUM;
                end
              end
              SEL_CSUM: begin
                r_state <= StIdle;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
              default: r_sel <= SEL_SYNC;
            endcase
          end
        end
        default: r_state <= StIdle;
      endcase
      if (w_abort) begin
        r_state <= StIdle;
        r_busy  <= 1'b0;
        r_err   <= 1'b1;
      end
    end
  end

  assign in_ready   = ~w_full;
  assign fifo_count = w_count;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign tx_data    = r_tx_data;
  assign tx_e       = r_tx_e;

endmodule

// File: tb/tb_serial_packet_tx.sv
// Randomised bench for serial_packet_tx: queue-based packet model plus a byte-sender model.
module tb_serial_packet_tx;

  localparam int unsigned Depth = 16;
  localparam int unsigned CW    = $clog2(Depth) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          start;
  logic [7:0]    start_len;
  logic          busy;
  logic          done;
  logic          err;
  logic [7:0]    tx_data;
  logic          tx_e;
  logic          tx_avail;
  logic [CW-1:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [7:0] model_q[$];
  logic [7:0] cap_q[$];
  int txe_cnt   = 0;
  int done_cnt  = 0;
  int spurious  = 0;
  int frame_len = 12;
  int sender_fc = 0;
  bit hold_low  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  serial_packet_tx #(
    .FIFO_DEPTH(Depth)
`ifdef SERIAL_PKT_TIMEOUT_EN
    , .TIMEOUT_CYCLES(64)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .start     (start),
    .start_len (start_len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .tx_data   (tx_data),
    .tx_e      (tx_e),
    .tx_avail  (tx_avail),
    .fifo_count(fifo_count)
  );

  // Byte sender: accepts a request while idle, then stays unavailable for frame_len cycles.
  initial begin
    tx_avail = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sender_fc = 0;
        tx_avail  = 1'b1;
      end else begin
        if (tx_e === 1'b1) begin
          txe_cnt++;
          if (tx_avail) begin
            cap_q.push_back(tx_data);
            sender_fc = frame_len;
            tx_avail  = 1'b0;
          end else begin
            spurious++;
          end
        end else if (sender_fc > 0) begin
          sender_fc--;
        end
        if (done === 1'b1) done_cnt++;
        if (hold_low) tx_avail = 1'b0;
        else if (sender_fc == 0) tx_avail = 1'b1;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic exp_rdy;
    exp_rdy = (model_q.size() < Depth);
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b", in_ready, exp_rdy);
    end
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    if (exp_rdy) model_q.push_back(b);
  endtask

  task automatic run_packet(input int len, input int hold, input bit push_during);
    logic [7:0] exp_q[$];
    logic [7:0] cs;
    logic [7:0] got;
    int start_cyc;
    int first_e;
    int n;
    bit data_ok;
    cs = 8'(len);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(model_q[i]);
      cs ^= model_q[i];
    end
    exp_q.push_back(cs);
    if (hold > 0) begin
      hold_low = 1'b1;
      tick();
    end
    cap_q.delete();
    txe_cnt  = 0;
    done_cnt = 0;
    spurious = 0;
    start     = 1'b1;
    start_len = 8'(len);
    start_cyc = cycle;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL start_accept: got busy=%b err=%b expected busy=1 err=0", busy, err);
    end
    data_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (tx_data !== 8'hA5 || txe_cnt != 0) data_ok = 1'b0;
    end
    if (hold > 0) begin
      checks++;
      if (!data_ok) begin
        errors++;
        $display("FAIL hold_sync: got tx_data=%h tx_e_count=%0d expected a5 and 0", tx_data,
                 txe_cnt);
      end
      hold_low = 1'b0;
    end
    first_e = -1;
    n = 0;
    while (done_cnt == 0 && n < 5000) begin
      if (push_during && model_q.size() < Depth && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        model_q.push_back(in_data);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      n++;
      if (first_e < 0 && txe_cnt > 0) first_e = cycle;
    end
    in_valid = 1'b0;
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL packet_done: got no done in %0d cycles expected one", n);
    end
    tick();
    tick();
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("FAIL tx_byte[%0d]: got %h expected %h", i, got, exp_q[i]);
      end
    end
    checks++;
    if (txe_cnt != len + 3 || spurious != 0) begin
      errors++;
      $display("FAIL tx_e_count: got %0d (spurious %0d) expected %0d", txe_cnt, spurious,
               len + 3);
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got done_count=%0d busy=%b expected 1 and 0", done_cnt, busy);
    end
    if (hold == 0) begin
      checks++;
      if (first_e < 0 || first_e - start_cyc < 3) begin
        errors++;
        $display("FAIL latency: got %0d expected >= 3", first_e - start_cyc);
      end
    end
    for (int i = 0; i < len; i++) void'(model_q.pop_front());
    checks++;
    if (fifo_count !== CW'(model_q.size())) begin
      errors++;
      $display("FAIL fifo_count_after: got %0d expected %0d", fifo_count, model_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
    checks++;
    if (tx_e !== 1'b0) begin errors++; $display("FAIL rst_tx_e: got %b expected 0", tx_e); end
    checks++;
    if (tx_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_tx_data: got %h expected 00", tx_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (fifo_count !== '0) begin
      errors++;
      $display("FAIL rst_fifo_count: got %0d expected 0", fifo_count);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    run_packet(3, 0, 1'b0);
  endtask

  task automatic test_len_err();
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    txe_cnt = 0;
    foreach (model_q[i]) begin end
    start     = 1'b1;
    start_len = 8'd4;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len_over: got err=%b busy=%b expected err=1 busy=0", err, busy);
    end
    checks++;
    if (fifo_count !== CW'(model_q.size()) || txe_cnt != 0) begin
      errors++;
      $display("FAIL len_over_nochange: got count=%0d tx_e=%0d expected %0d and 0", fifo_count,
               txe_cnt, model_q.size());
    end
    start     = 1'b1;
    start_len = 8'd0;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || txe_cnt != 0) begin
      errors++;
      $display("FAIL len_zero: got err=%b busy=%b expected err=1 busy=0", err, busy);
    end
    run_packet(model_q.size(), 0, 1'b0);
  endtask

  task automatic test_hold();
    push_byte(8'($urandom));
    run_packet(1, 50, 1'b0);
  endtask

  task automatic test_full();
    while (model_q.size() < Depth) push_byte(8'($urandom));
    push_byte(8'hEE);
    checks++;
    if (fifo_count !== CW'(Depth) || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full: got count=%0d in_ready=%b expected %0d and 0", fifo_count, in_ready,
               Depth);
    end
    run_packet(Depth, 0, 1'b0);
    push_byte(8'h5A);
    checks++;
    if (fifo_count !== CW'(1)) begin
      errors++;
      $display("FAIL wrap_push: got count=%0d expected 1", fifo_count);
    end
    run_packet(1, 0, 1'b0);
  endtask

  task automatic test_random();
    int len;
    for (int k = 0; k < 6; k++) begin
      frame_len = $urandom_range(1, 15);
      len = $urandom_range(1, 8);
      while (model_q.size() < len) push_byte(8'($urandom));
      run_packet(len, 0, 1'b1);
    end
    frame_len = 12;
    while (model_q.size() > 0) run_packet(model_q.size() > 8 ? 8 : model_q.size(), 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int n;
    for (int i = 0; i < 4; i++) push_byte(8'($urandom));
    cap_q.delete();
    start     = 1'b1;
    start_len = 8'd4;
    tick();
    start = 1'b0;
    n = 0;
    while (cap_q.size() < 4 && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (cap_q.size() < 4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reach: got %0d bytes busy=%b expected 4 bytes busy=1", cap_q.size(),
               busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, tx_e, tx_data, in_ready} !== 13'b0_0_0_0_00000000_1 ||
        fifo_count !== '0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b done=%b err=%b tx_e=%b data=%h rdy=%b cnt=%0d expected 0 0 0 0 00 1 0",
               busy, done, err, tx_e, tx_data, in_ready, fifo_count);
    end
    tick();
    tick();
    rst_n = 1'b1;
    model_q.delete();
    tick();
    checks++;
    if (fifo_count !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got count=%0d busy=%b expected 0 0", fifo_count, busy);
    end
    push_byte(8'h77);
    push_byte(8'h88);
    run_packet(2, 0, 1'b0);
  endtask

`ifdef SERIAL_PKT_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    for (int i = 0; i < 3; i++) push_byte(8'($urandom));
    cap_q.delete();
    txe_cnt  = 0;
    done_cnt = 0;
    start     = 1'b1;
    start_len = 8'd3;
    tick();
    start = 1'b0;
    n = 0;
    while (cap_q.size() < 2 && n < 500) begin
      tick();
      n++;
    end
    hold_low = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (n < 60 || n > 70) begin
      errors++;
      $display("FAIL tmo_time: got %0d cycles expected about 65", n);
    end
    checks++;
    if (err !== 1'b1 || done_cnt != 0 || txe_cnt != 2) begin
      errors++;
      $display("FAIL tmo_flags: got err=%b done=%0d tx_e=%0d expected 1 0 2", err, done_cnt,
               txe_cnt);
    end
    for (int i = 0; i < 3; i++) void'(model_q.pop_front());
    checks++;
    if (fifo_count !== CW'(model_q.size())) begin
      errors++;
      $display("FAIL tmo_drain: got %0d expected %0d", fifo_count, model_q.size());
    end
    hold_low = 1'b0;
    tick();
    tick();
    push_byte(8'h3C);
    run_packet(model_q.size(), 0, 1'b0);
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    start     = 1'b0;
    start_len = 8'h00;
    test_reset();
    test_basic();
    test_len_err();
    test_hold();
    test_full();
    test_random();
    test_reset_mid();
`ifdef SERIAL_PKT_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
